// File: rtl/enc_8to3_serializer.sv
// Bitmap-to-index serializer: accepts a WIDTH-bit request bitmap and emits the
// binary index of each set bit, lowest first, over a valid/ready stream.
module enc_8to3_serializer #(
  parameter  int WIDTH  = 8,
  localparam int CODE_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  req,
  input  logic              req_valid,
  output logic              req_ready,
  output logic [CODE_W-1:0] code,
  output logic [WIDTH-1:0]  code_onehot,
  output logic              code_valid,
  input  logic              code_ready,
  output logic              code_last,
  output logic [CODE_W:0]   remaining,
  output logic              drop_zero
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state;
  logic [WIDTH-1:0]   pending;
  logic [WIDTH-1:0]   src;
  logic [CODE_W-1:0]  src_idx;
  logic [CODE_W:0]    src_cnt;

  function automatic logic [CODE_W-1:0] lowest_idx(input logic [WIDTH-1:0] v);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [CODE_W:0] pop_count(input logic [WIDTH-1:0] v);
    logic [CODE_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + (CODE_W+1)'(v[i]);
    end
    return cnt;
  endfunction

  assign req_ready = (state == IDLE);

  // The next beat is derived either from a freshly accepted bitmap or from
  // the pending bits with the currently presented one removed.
  always_comb begin
    src     = (state == IDLE) ? req : (pending & ~code_onehot);
    src_idx = lowest_idx(src);
    src_cnt = pop_count(src);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pending     <= '0;
      code        <= '0;
      code_onehot <= '0;
      code_valid  <= 1'b0;
      code_last   <= 1'b0;
      remaining   <= '0;
      drop_zero   <= 1'b0;
    end else begin
      drop_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req != '0) begin
              state       <= SEND;
              pending     <= req;
              code        <= src_idx;
              code_onehot <= WIDTH'(1) << src_idx;
              code_valid  <= 1'b1;
              remaining   <= src_cnt;
              code_last   <= (src_cnt == (CODE_W+1)'(1));
            end else begin
              drop_zero <= 1'b1;
            end
          end
        end
        SEND: begin
          if (code_ready) begin
            pending <= src;
            if (code_last) begin
              state       <= IDLE;
              code        <= '0;
              code_onehot <= '0;
              code_valid  <= 1'b0;
              remaining   <= '0;
              code_last   <= 1'b0;
            end else begin
              code        <= src_idx;
              code_onehot <= WIDTH'(1) << src_idx;
              remaining   <= src_cnt;
              code_last   <= (src_cnt == (CODE_W+1)'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/enc_8to3_serializer.md
Name: enc_8to3_serializer

Overview:
- Inverse of the 3:8 decoder: accepts an 8-bit request bitmap and emits the 3-bit binary index of each set bit, one per accepted beat, lowest index first.
- Sequential front end for the decoder blocks; a decoder on `code` must reproduce each set bit of the original bitmap.
- Valid/ready handshake on both the input side and the output side.

Parameters:
- WIDTH, 8, bitmap width; must be a power of 2, at least 2.
- CODE_W, $clog2(WIDTH), output code width (3 at default); derived, never overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  WIDTH  request bitmap; sampled on the input handshake.
- req_valid  input  1  `req` is valid.
- req_ready  output  1  block can accept a bitmap.
- code  output  CODE_W  binary index of the current set bit.
- code_onehot  output  WIDTH  one-hot of `code` (1 << code); all zero when `code_valid` = 0.
- code_valid  output  1  `code` is valid.
- code_ready  input  1  downstream consumes `code`.
- code_last  output  1  current beat is the final set bit of this bitmap.
- remaining  output  CODE_W+1  set bits still pending, including the current beat.
- drop_zero  output  1  one-cycle pulse: an all-zero bitmap was accepted and discarded.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, pending register = 0.
  - code = 0, code_onehot = 0, code_valid = 0, code_last = 0, remaining = 0, drop_zero = 0.
  - req_ready = 1.
- States: IDLE, SEND.
- req_ready = (state == IDLE). It is a combinational decode of the state register. No new bitmap is accepted while SEND is active.
- IDLE, on req_valid && req_ready:
  - req != 0: pending <= req; go to SEND.
  - req == 0: stay in IDLE; drop_zero = 1 in the next cycle only; no code beat is produced.
- Latency: code_valid rises on the first clock edge after the accepting edge (1 cycle).
- All outputs except req_ready are registered.
- SEND:
  - code_valid = 1.
  - code = index of the lowest set bit of pending.
  - remaining = popcount(pending).
  - code_last = (remaining == 1).
- SEND, on code_valid && code_ready:
  - Clear that bit in pending.
  - If code_last: go to IDLE; code_valid = 0 and req_ready = 1 in the next cycle.
  - Otherwise: the next lowest set bit is presented in the next cycle. Back-to-back beats run at 1 per cycle with code_ready held high.
- Stall: while code_valid && !code_ready, code, code_onehot, code_last and remaining hold stable.
- Throughput:
  - A bitmap with N set bits occupies N cycles of SEND plus 1 acceptance cycle.
  - Full bitmap 0xFF yields codes 0..7 in 8 consecutive beats.
- Boundaries:
  - Single-bit bitmap gives one beat with code_last = 1 and remaining = 1.
  - Bit WIDTH-1 alone gives code = WIDTH-1 (7).
  - X/Z on `req` while req_valid = 0 is ignored.
- Reset mid-SEND: pending is discarded and the block returns to IDLE immediately. No code_last is emitted for the aborted bitmap.
- remaining is never 0 while code_valid = 1.

Test Plan:
- Reset, then req = 8'b0010_0101 with req_valid for 1 cycle, code_ready = 1 -> beats code = 0, 2, 5 on consecutive cycles; remaining 3, 2, 1; code_last only on code = 5; code_onehot = 01h, 04h, 20h; req_ready back to 1 the cycle after the last beat.
- req = 8'hFF, code_ready = 1 -> codes 0..7 in 8 consecutive cycles; code_last on 7; req_ready = 0 throughout SEND.
- req = 8'h90, code_ready low for 3 cycles after code_valid rises -> code = 4, remaining = 2 held stable for 3 cycles; then code = 7 with code_last = 1.
- req = 8'h00 accepted -> drop_zero pulses for exactly 1 cycle; code_valid stays 0; req_ready stays 1.
- Loopback: for every single-bit bitmap 8'h01..8'h80 feed code into decoder_3to8 -> decoder output equals the input bitmap; code_last = 1 each time.
- Reset pulse during second beat of 8'h0E -> all outputs zero while rst_n is low; after release, req_ready = 1 and the next bitmap 8'h40 produces a single beat code = 6.
